// File: rtl/mem_ctrl.sv
// Byte-serial load/store responder: splits 1/2/4-byte accesses into single-byte RAM cycles.
// Optional MEM_IO_STALL_EN: stores into IO space (addr[17:16] == 2'b11) wait while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] store_val,
    input  logic [1:0]  width,
    input  logic        sign,
    output logic [31:0] read_val,
    output logic        done,
    output logic        busy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] base_a;
    logic [31:0] store_d;
    logic [31:0] rbuf;
    logic [1:0]  wid;
    logic        sgn;
    logic [2:0]  k;
    logic [1:0]  s;
    logic        issued;
    logic        arriving;
    logic        stalled;

    logic [2:0]  last_n;
    logic [2:0]  s_next;
    logic [31:0] wr_a;
    logic [31:0] assembled;
    logic        io_stall;

    function automatic logic [2:0] nbytes_of(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] w, input logic sx);
        case (w)
            2'd0:    return sx ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
            2'd1:    return sx ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] i);
        return v[8*i +: 8];
    endfunction

    assign last_n = nbytes_of(wid);
    assign s_next = {1'b0, s} + 3'd1;
    assign wr_a   = (state == IDLE) ? addr : base_a + {29'b0, k};

`ifdef MEM_IO_STALL_EN
    assign io_stall = (wr_a[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    always_comb begin
        assembled = rbuf;
        assembled[8*s +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            read_val <= 32'b0;
            mem_a    <= 32'b0;
            mem_dout <= 8'b0;
            mem_wr   <= 1'b0;
            k        <= 3'd0;
            s        <= 2'd0;
            issued   <= 1'b0;
            arriving <= 1'b0;
            stalled  <= 1'b0;
        end else if (!rdy_in) begin
            // Frozen; a load points the RAM back at the byte it still needs.
            mem_wr <= 1'b0;
            if (state == READ) begin
                mem_a   <= base_a + {30'b0, s};
                stalled <= 1'b1;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear && we) begin
                        base_a   <= addr;
                        store_d  <= store_val;
                        wid      <= width;
                        state    <= WRITE;
                        busy     <= 1'b1;
                        mem_a    <= addr;
                        mem_dout <= store_val[7:0];
                        if (io_stall) begin
                            k      <= 3'd0;
                            mem_wr <= 1'b0;
                        end else begin
                            k      <= 3'd1;
                            mem_wr <= 1'b1;
                        end
                    end else if (!clear && re) begin
                        base_a   <= addr;
                        wid      <= width;
                        sgn      <= sign;
                        state    <= READ;
                        busy     <= 1'b1;
                        mem_a    <= addr;
                        mem_wr   <= 1'b0;
                        k        <= 3'd1;
                        s        <= 2'd0;
                        issued   <= 1'b1;
                        arriving <= 1'b0;
                        stalled  <= 1'b0;
                    end
                end
                READ: begin
                    if (clear) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (stalled) begin
                        // Byte s was re-addressed during the stall and arrives next cycle.
                        stalled  <= 1'b0;
                        arriving <= 1'b1;
                        if (s_next < last_n) begin
                            mem_a  <= base_a + {29'b0, s_next};
                            k      <= s_next + 3'd1;
                            issued <= 1'b1;
                        end else begin
                            issued <= 1'b0;
                        end
                    end else begin
                        if (arriving) begin
                            rbuf <= assembled;
                            s    <= s + 2'd1;
                            if ({1'b0, s} == last_n - 3'd1) begin
                                read_val <= extend(assembled, wid, sgn);
                                done     <= 1'b1;
                                state    <= DONE;
                            end
                        end
                        arriving <= issued;
                        if (k < last_n) begin
                            mem_a  <= base_a + {29'b0, k};
                            k      <= k + 3'd1;
                            issued <= 1'b1;
                        end else begin
                            issued <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    // Stores are already committed, so clear does not interrupt them.
                    if (k == last_n) begin
                        mem_wr   <= 1'b0;
                        done     <= 1'b1;
                        read_val <= 32'b0;
                        state    <= DONE;
                    end else if (io_stall) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_a    <= wr_a;
                        mem_dout <= byte_of(store_d, k[1:0]);
                        mem_wr   <= 1'b1;
                        k        <= k + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table of load/store vectors, scoreboard of expected completions.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_val = 32'b0;
    logic [1:0]  width = 2'd0;
    logic        sign = 1'b0;
    logic [31:0] read_val;
    logic        done;
    logic        busy;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .re(re), .we(we), .addr(addr), .store_val(store_val), .width(width), .sign(sign),
        .read_val(read_val), .done(done), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
    typedef struct {bit wr; logic [31:0] a; logic [31:0] sv; logic [1:0] w; bit sg; logic [31:0] rv; int lat;} vec_t;
    typedef struct {logic [31:0] rv; int lat;} exp_t;

    logic [7:0] ram [0:4095];
    wr_t  wlog [$];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    // Synchronous byte RAM: address sampled at an edge, data presented the following cycle.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v, input int stall_at, input int stall_len,
                       input int clear_at, input int io_len, input bit expect_done);
        int n;
        bit got;
        int nexp_wr;
        exp_t e;
        logic [31:0] sv;
        wlog.delete();
        nexp_wr = v.wr ? ((v.w == 2'd0) ? 1 : (v.w == 2'd1) ? 2 : 4) : 0;
        we = v.wr; re = !v.wr; addr = v.a; store_val = v.sv; width = v.w; sign = v.sg;
        io_buffer_full = (io_len > 0);
        if (expect_done) sb.push_back('{rv: v.rv, lat: v.lat});
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk_in); #1;
            n++;
            if (done) got = 1;
            if (n == 1) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            if (stall_len > 0 && n == stall_at) rdy_in = 1'b0;
            if (stall_len > 0 && n == stall_at + stall_len) rdy_in = 1'b1;
            if (clear_at > 0 && n == clear_at) begin
                clear = 1'b1;
                if (!v.wr) re = 1'b0;
            end
            if (clear_at > 0 && n == clear_at + 1) begin
                clear = 1'b0;
                if (!v.wr) check({tag, "_idle_after_clear"}, {31'b0, busy}, 32'd0);
            end
            if (io_len > 0 && n == io_len) io_buffer_full = 1'b0;
        end
        if (expect_done) begin
            check({tag, "_done_seen"}, {31'b0, got}, 32'd1);
            if (got) begin
                e = sb.pop_front();
                check({tag, "_read_val"}, read_val, e.rv);
                check({tag, "_latency"}, n, e.lat);
            end
        end else begin
            check({tag, "_no_done"}, {31'b0, got}, 32'd0);
            check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
            check({tag, "_read_val_kept"}, read_val, v.rv);
        end
        re = 1'b0; we = 1'b0;
        @(posedge clk_in); #1;
        if (expect_done) check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_write_count"}, wlog.size(), nexp_wr);
        for (int i = 0; i < wlog.size() && i < nexp_wr; i++) begin
            sv = v.sv >> (8 * i);
            check({tag, "_wr_addr"}, wlog[i].a, v.a + i);
            check({tag, "_wr_data"}, {24'b0, wlog[i].d}, {24'b0, sv[7:0]});
        end
        io_buffer_full = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    endtask

    vec_t tbl [14];
    vec_t h;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h020] = 8'h80; ram[12'h021] = 8'h80; ram[12'h022] = 8'hFF;
        ram[12'h000] = 8'hA0; ram[12'h001] = 8'hB1; ram[12'hFFE] = 8'h01;

        //          wr    addr           store_val      w     sg    read_val       lat
        tbl[0]  = '{1'b0, 32'h00000100, 32'h00000000, 2'd2, 1'b0, 32'h12345678, 6};
        tbl[1]  = '{1'b0, 32'h00000020, 32'h00000000, 2'd0, 1'b1, 32'hFFFFFF80, 3};
        tbl[2]  = '{1'b0, 32'h00000020, 32'h00000000, 2'd0, 1'b0, 32'h00000080, 3};
        tbl[3]  = '{1'b0, 32'h00000021, 32'h00000000, 2'd1, 1'b1, 32'hFFFFFF80, 4};
        tbl[4]  = '{1'b0, 32'h00000021, 32'h00000000, 2'd1, 1'b0, 32'h0000FF80, 4};
        tbl[5]  = '{1'b1, 32'h000003FF, 32'hAABBCCDD, 2'd1, 1'b0, 32'h00000000, 3};
        tbl[6]  = '{1'b0, 32'h000003FF, 32'h00000000, 2'd1, 1'b0, 32'h0000CCDD, 4};
        tbl[7]  = '{1'b1, 32'h00000200, 32'h11223344, 2'd2, 1'b0, 32'h00000000, 5};
        tbl[8]  = '{1'b0, 32'h00000200, 32'h00000000, 2'd2, 1'b1, 32'h11223344, 6};
        tbl[9]  = '{1'b0, 32'h00000100, 32'h00000000, 2'd3, 1'b1, 32'h12345678, 6};
        tbl[10] = '{1'b0, 32'h00000101, 32'h00000000, 2'd0, 1'b1, 32'h00000056, 3};
        tbl[11] = '{1'b1, 32'hFFFFFFFF, 32'h0000005A, 2'd0, 1'b0, 32'h00000000, 2};
        tbl[12] = '{1'b0, 32'hFFFFFFFE, 32'h00000000, 2'd2, 1'b0, 32'hB1A05A01, 6};
        tbl[13] = '{1'b0, 32'h00000101, 32'h00000000, 2'd1, 1'b1, 32'h00003456, 4};

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_read_val", read_val, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        rst_in = 1'b0;

        for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), tbl[i], 0, 0, 0, 0, 1'b1);

        // Load flushed on its second READ cycle: no done, previous result kept.
        h = '{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h00003456, 0};
        run("clear_load", h, 0, 0, 2, 0, 1'b0);

        // Store sees clear but still writes all four bytes.
        h = '{1'b1, 32'h300, 32'hCAFEBABE, 2'd2, 1'b0, 32'h0, 5};
        run("clear_store", h, 0, 0, 2, 0, 1'b1);

        // rdy_in low for three cycles mid word load.
        h = '{1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h12345678, 10};
        run("rdy_stall", h, 2, 3, 0, 0, 1'b1);

        // Byte store into IO space with the sink full for five cycles.
`ifdef MEM_IO_STALL_EN
        h = '{1'b1, 32'h30000, 32'h77, 2'd0, 1'b0, 32'h0, 7};
`else
        h = '{1'b1, 32'h30000, 32'h77, 2'd0, 1'b0, 32'h0, 2};
`endif
        run("io_store", h, 0, 0, 0, 5, 1'b1);

        // Reset in the middle of a load abandons it.
        re = 1'b1; addr = 32'h100; width = 2'd2; sign = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_read_val", read_val, 32'd0);
        check("midrst_mem_wr", {31'b0, mem_wr}, 32'd0);
        rst_in = 1'b0; re = 1'b0;

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
